// File: rtl/up_down_counter.sv
// Up/down modulo counter with optional saturation and step size.
// Terminal-count flags are decoded from the registered count; wrap is a registered pulse.
module up_down_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int SATURATE = 0,
    parameter int STEP     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             UpOrDown,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic             dir_q
);

    if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
        $error("up_down_counter: MODULUS out of range");
    end
    if (STEP < 1 || STEP > MODULUS - 1) begin : g_bad_step
        $error("up_down_counter: STEP out of range");
    end

    // One extra bit keeps the overflow/underflow compares exact.
    localparam logic [WIDTH:0]   MOD_X  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   cnt_x, up_sum, up_wrap, dn_diff, dn_wrap;

    always_comb begin
        cnt_x   = {1'b0, count_q};
        up_sum  = cnt_x + STEP_X;
        up_wrap = up_sum - MOD_X;
        dn_diff = cnt_x - STEP_X;
        dn_wrap = cnt_x + MOD_X - STEP_X;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (UpOrDown) begin
            if (up_sum >= MOD_X) begin
                wrap_d  = 1'b1;
                count_d = (SATURATE != 0) ? MAX_V : up_wrap[WIDTH-1:0];
            end else begin
                count_d = up_sum[WIDTH-1:0];
            end
        end else begin
            if (cnt_x < STEP_X) begin
                wrap_d  = 1'b1;
                count_d = (SATURATE != 0) ? '0 : dn_wrap[WIDTH-1:0];
            end else begin
                count_d = dn_diff[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            dir_q   <= UpOrDown;
        end
    end

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign at_max = (count_q == MAX_V);
    assign at_min = (count_q == '0);

endmodule

// File: tb/tb_up_down_counter.sv
// Bench for up_down_counter: default, saturating (mod 6) and step-2 (mod 5) instances
// run side by side against a reference model through expected-value queues.
module tb_up_down_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dir_a = 1'b0, dir_b = 1'b0, dir_c = 1'b0;
    logic [2:0] cnt_a, cnt_b, cnt_c;
    logic       max_a, max_b, max_c, min_a, min_b, min_c;
    logic       wr_a, wr_b, wr_c, dq_a, dq_b, dq_c;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int cnt;
        int wr;
        int dir;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    int   ma = 0, mb = 0, mc = 0;

    always #5 clk = ~clk;

    up_down_counter u_a (
        .clk(clk), .reset(rst_n), .UpOrDown(dir_a), .count(cnt_a),
        .at_max(max_a), .at_min(min_a), .wrap(wr_a), .dir_q(dq_a)
    );

    up_down_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1), .STEP(1)) u_b (
        .clk(clk), .reset(rst_n), .UpOrDown(dir_b), .count(cnt_b),
        .at_max(max_b), .at_min(min_b), .wrap(wr_b), .dir_q(dq_b)
    );

    up_down_counter #(.WIDTH(3), .MODULUS(5), .SATURATE(0), .STEP(2)) u_c (
        .clk(clk), .reset(rst_n), .UpOrDown(dir_c), .count(cnt_c),
        .at_max(max_c), .at_min(min_c), .wrap(wr_c), .dir_q(dq_c)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void mdl_next(input int cnt, input int up, input int md,
                                     input int st, input int sat,
                                     output int nxt, output int wr);
        wr = 0;
        if (up != 0) begin
            nxt = cnt + st;
            if (nxt >= md) begin
                wr  = 1;
                nxt = (sat != 0) ? md - 1 : nxt - md;
            end
        end else begin
            if (cnt < st) begin
                wr  = 1;
                nxt = (sat != 0) ? 0 : cnt + md - st;
            end else begin
                nxt = cnt - st;
            end
        end
    endfunction

    task automatic check_one(input string nm, inout exp_t q[$], input int md,
                             input logic [2:0] c, input logic w, input logic d,
                             input logic mx, input logic mn);
        exp_t e;
        if (q.size() == 0) begin
            chk({nm, "_queue_empty"}, 0, 1);
            return;
        end
        e = q.pop_front();
        chk({nm, "_count"}, int'(c), e.cnt);
        chk({nm, "_wrap"}, int'(w), e.wr);
        chk({nm, "_dir_q"}, int'(d), e.dir);
        chk({nm, "_at_max"}, int'(mx), int'(e.cnt == md - 1));
        chk({nm, "_at_min"}, int'(mn), int'(e.cnt == 0));
    endtask

    task automatic cyc(input int da, input int db, input int dc);
        exp_t e;
        int   n, w;
        @(negedge clk);
        dir_a = da[0];
        dir_b = db[0];
        dir_c = dc[0];
        mdl_next(ma, da, 8, 1, 0, n, w); ma = n; e = '{n, w, da}; qa.push_back(e);
        mdl_next(mb, db, 6, 1, 1, n, w); mb = n; e = '{n, w, db}; qb.push_back(e);
        mdl_next(mc, dc, 5, 2, 0, n, w); mc = n; e = '{n, w, dc}; qc.push_back(e);
        @(posedge clk);
        #1;
        check_one("a", qa, 8, cnt_a, wr_a, dq_a, max_a, min_a);
        check_one("b", qb, 6, cnt_b, wr_b, dq_b, max_b, min_b);
        check_one("c", qc, 5, cnt_c, wr_c, dq_c, max_c, min_c);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_a_count"}, int'(cnt_a), 0);
        chk({tag, "_b_count"}, int'(cnt_b), 0);
        chk({tag, "_c_count"}, int'(cnt_c), 0);
        chk({tag, "_a_at_min"}, int'(min_a), 1);
        chk({tag, "_a_at_max"}, int'(max_a), 0);
        chk({tag, "_a_wrap"}, int'(wr_a), 0);
        chk({tag, "_a_dir_q"}, int'(dq_a), 0);
        chk({tag, "_b_wrap"}, int'(wr_b), 0);
        chk({tag, "_c_wrap"}, int'(wr_c), 0);
    endtask

    initial begin
        int tbl_a[9];
        int tbl_b[9];
        int tbl_c[5];
        tbl_a = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        tbl_b = '{1, 2, 3, 4, 5, 5, 5, 5, 5};
        tbl_c = '{3, 1, 4, 2, 0};

        // Reset held across edges with the direction toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dir_a = ~dir_a;
            dir_b = ~dir_b;
            dir_c = ~dir_c;
            @(posedge clk);
            #1;
            check_reset_state("rst_hold");
        end
        rst_n = 1'b1;

        // a counts down through its wrap; b saturates high; c steps up by 2.
        for (int i = 0; i < 9; i++) begin
            cyc(0, 1, 1);
            chk("a_down_seq", int'(cnt_a), tbl_a[i]);
            chk("b_sat_up_seq", int'(cnt_b), tbl_b[i]);
        end
        cyc(1, 0, 1);
        chk("c_back_to_zero", int'(cnt_c), 0);

        // c counts down from 0 modulo 5; b saturates low.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0);
            chk("c_down_seq", int'(cnt_c), tbl_c[i]);
        end
        chk("b_low_clamp", int'(cnt_b), 0);

        // Direction flip on the default counter: 5 -> 4 -> 3.
        cyc(0, 0, 0);
        chk("a_flip_1", int'(cnt_a), 4);
        cyc(0, 1, 1);
        chk("a_flip_2", int'(cnt_a), 3);

        for (int i = 0; i < 60; i++)
            cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));

        for (int k = 0; k < 8 && ma != 5; k++)
            cyc(1, 1, 1);
        chk("a_before_midreset", int'(cnt_a), 5);

        // Asynchronous reset between edges must clear immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_async");
        ma = 0;
        mb = 0;
        mc = 0;
        @(posedge clk);
        #1;
        check_reset_state("rst_edge_ignored");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            cyc(1, 1, 1);
        chk("a_resume", int'(cnt_a), 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/up_down_counter.md
Name: up_down_counter

Overview:
- Synchronous up/down modulo counter with a selectable direction input and terminal-count status outputs.
- Used as a generic event and index counter in control paths.
- Default configuration is a 3-bit, modulo-8, wrapping counter that advances every clock.
- Optional saturation mode and optional non-power-of-two modulus are set by parameters.

Parameters:
- WIDTH, 3, bit width of count.
- MODULUS, 2**WIDTH, number of states. count ranges 0..MODULUS-1. Legal range 2..2**WIDTH; any other value is a configuration error.
- SATURATE, 0, 0 = wrap at the ends, 1 = hold at the ends.
- STEP, 1, increment/decrement amount per clock. Legal range 1..MODULUS-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- UpOrDown  input  1  direction: 1 = count up, 0 = count down. Sampled on every rising clk edge.
- count  output  WIDTH  current counter value, registered.
- at_max  output  1  combinational, 1 when count == MODULUS-1.
- at_min  output  1  combinational, 1 when count == 0.
- wrap  output  1  registered one-cycle pulse; 1 in the cycle after a wrap (or saturation clamp) event.
- dir_q  output  1  registered copy of the UpOrDown value that produced the current count.

Behaviour:
- Reset, while reset == 0 (asynchronous, immediate):
  - count = 0, wrap = 0, dir_q = 0.
  - at_min = 1, at_max = 0.
  - Clock edges are ignored while reset is held low.
- Reset release: the first rising edge with reset == 1 performs the first count update. No extra wait cycle.
- Counting: the counter advances on every rising edge out of reset. There is no enable; latency is 1 clock from edge to new count.
- Up (UpOrDown == 1):
  - Next value = count + STEP.
  - If that reaches or exceeds MODULUS:
    - SATURATE = 0: next = count + STEP - MODULUS (modular wrap).
    - SATURATE = 1: next = MODULUS-1.
- Down (UpOrDown == 0):
  - Next value = count - STEP.
  - If count < STEP:
    - SATURATE = 0: next = count + MODULUS - STEP.
    - SATURATE = 1: next = 0.
- Arithmetic is carried out at WIDTH+1 bits so the wrap/overflow test is exact, then truncated to WIDTH.
- wrap pulse:
  - Set to 1 for exactly the cycle following any edge where the wrap or clamp branch was taken, otherwise 0.
  - In saturate mode, holding at the end keeps wrap = 1 every cycle the clamp branch is taken.
- Direction change mid-count: takes effect on the very next edge. No pipeline or hysteresis; e.g. 5 up -> 6, then switch to down -> 5.
- dir_q updates every edge to the sampled UpOrDown.
- Reset asserted mid-count overrides everything asynchronously. The count resumes from 0 after release.
- count never leaves the 0..MODULUS-1 range in any mode.

Test Plan:
- Reset: hold reset=0 for 3 cycles with UpOrDown toggling -> count=0, at_min=1, wrap=0 throughout. Assert reset mid-count (count=5) between edges -> count=0 immediately, without waiting for an edge.
- Down wrap (defaults): release reset with UpOrDown=0 -> count sequence 7,6,5,4,3,2,1,0,7. wrap=1 only in the cycle showing the 0->7 transition result (count=7), at_max=1 at count=7.
- Up wrap (defaults): UpOrDown=1 from count=0 -> 1,2,...,7,0,1. wrap pulses once when count returns to 0. at_max high only at 7.
- Direction flip: count up to 4, set UpOrDown=0 -> next values 3,2. dir_q follows UpOrDown one edge later.
- Saturate (SATURATE=1, MODULUS=6): count up from 0 for 8 edges -> 1,2,3,4,5,5,5,5 with wrap=1 on the held cycles. Count down for 8 edges -> 4,3,2,1,0,0,0,0.
- Step/modulus (MODULUS=5, STEP=2, wrap): from 0 counting up -> 2,4,1,3,0. Counting down from 0 -> 3,1,4,2,0.
